// File: rtl/rgb_link_pkg.sv
// Shared definitions for the byte-serial RGB link (serializer and assembler sides).
package rgb_link_pkg;

  localparam int CNT_W = 11;
  localparam logic [CNT_W-1:0] TIMEOUT_MAX_DFLT = 11'd1000;

  typedef enum logic [1:0] {
    ST_WAIT_R = 2'd0,
    ST_WAIT_G = 2'd1,
    ST_WAIT_B = 2'd2
  } link_state_e;

  // Position of each colour byte on the wire.
  typedef enum logic [1:0] {
    BYTE_R = 2'd0,
    BYTE_G = 2'd1,
    BYTE_B = 2'd2
  } byte_order_e;

endpackage

// File: rtl/rgb_byte_assembler_if.sv
// Byte stream in, assembled pixel and error status out.
interface rgb_byte_assembler_if #(
  parameter int ERR_CNT_W = 8
);
  logic [7:0]           data_in;
  logic                 data_in_ready;
  logic [7:0]           r_data_out;
  logic [7:0]           g_data_out;
  logic [7:0]           b_data_out;
  logic                 pixel_valid;
  logic                 frame_err;
  logic [ERR_CNT_W-1:0] err_count;

  modport master (
    output data_in, data_in_ready,
    input  r_data_out, g_data_out, b_data_out, pixel_valid, frame_err, err_count
  );

  modport slave (
    input  data_in, data_in_ready,
    output r_data_out, g_data_out, b_data_out, pixel_valid, frame_err, err_count
  );
endinterface

// File: rtl/link_timeout_cnt.sv
// Inter-byte idle counter; expire fires on the idle cycle that would reach TIMEOUT_MAX.
module link_timeout_cnt
  import rgb_link_pkg::*;
#(
  parameter logic [CNT_W-1:0] TIMEOUT_MAX = TIMEOUT_MAX_DFLT
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);
  localparam logic [CNT_W-1:0] LAST = TIMEOUT_MAX - 11'd1;

  logic [CNT_W-1:0] cnt;

  // clr wins so a strobe landing on the last idle cycle is never a timeout.
  assign expire = en && !clr && (cnt == LAST);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)          cnt <= '0;
    else if (clr || expire)  cnt <= '0;
    else if (en)             cnt <= cnt + CNT_W'(1);
  end
endmodule

// File: rtl/rgb_byte_assembler.sv
// Reassembles R/G/B byte triples into pixels; drops stalled triples and counts drops.
module rgb_byte_assembler
  import rgb_link_pkg::*;
#(
  parameter logic [CNT_W-1:0] TIMEOUT_MAX = TIMEOUT_MAX_DFLT,
  parameter int               ERR_CNT_W   = 8
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  rgb_byte_assembler_if.slave  link
);
  link_state_e          state;
  logic [7:0]           r_hold, g_hold;
  logic [ERR_CNT_W-1:0] err_cnt;
  logic                 stb, waiting, expire;

  assign stb     = link.data_in_ready;
  assign waiting = (state != ST_WAIT_R);
  assign link.err_count = err_cnt;

  link_timeout_cnt #(.TIMEOUT_MAX(TIMEOUT_MAX)) u_tmo (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .clr       (!waiting || stb),
    .en        (waiting && !stb),
    .expire    (expire)
  );

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state            <= ST_WAIT_R;
      r_hold           <= '0;
      g_hold           <= '0;
      link.r_data_out  <= '0;
      link.g_data_out  <= '0;
      link.b_data_out  <= '0;
      link.pixel_valid <= 1'b0;
      link.frame_err   <= 1'b0;
      err_cnt          <= '0;
    end else begin
      link.pixel_valid <= 1'b0;
      link.frame_err   <= 1'b0;
      if (expire) begin
        // Partial triple dropped; outputs keep the last complete pixel.
        state          <= ST_WAIT_R;
        link.frame_err <= 1'b1;
        if (err_cnt != '1) err_cnt <= err_cnt + ERR_CNT_W'(1);
      end else begin
        unique case (state)
          ST_WAIT_R: if (stb) begin
            r_hold <= link.data_in;
            state  <= ST_WAIT_G;
          end
          ST_WAIT_G: if (stb) begin
            g_hold <= link.data_in;
            state  <= ST_WAIT_B;
          end
          ST_WAIT_B: if (stb) begin
            link.r_data_out  <= r_hold;
            link.g_data_out  <= g_hold;
            link.b_data_out  <= link.data_in;
            link.pixel_valid <= 1'b1;
            state            <= ST_WAIT_R;
          end
          default: state <= ST_WAIT_R;
        endcase
      end
    end
  end
endmodule
